// File: rtl/uart_host_pkg.sv
// uart_host_pkg: shared FSM encoding, UART register map and status bit positions
package uart_host_pkg;
    typedef enum logic [1:0] {IDLE, STAT, RDAT, WDAT} state_t;
    localparam logic ADR_DATA = 1'b0;
    localparam logic ADR_CSR = 1'b1;
    localparam int TXRDY = 7;
    localparam int RXRDY = 3;
    localparam int BRK = 2;
    localparam int PERR = 1;
    localparam int OVF = 0;
`ifdef UART_HOST_ERR_EN
    localparam int RX_W = 11;
`else
    localparam int RX_W = 8;
`endif
endpackage

// File: rtl/uart_host_fifo.sv
// uart_host_fifo: 2**AW-entry FIFO; push and pop in the same cycle both succeed, even when full
module uart_host_fifo #(
    parameter int W = 8,
    parameter int AW = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    logic [W-1:0] mem_q [2**AW];
    logic [AW:0] wr_q, rd_q;
    logic do_push, do_pop;
    assign empty_o = wr_q == rd_q;
    assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || pop_i);
    assign dout_o = mem_q[rd_q[AW-1:0]];
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= do_push ? wr_q + 1'b1 : wr_q;
            rd_q <= do_pop ? rd_q + 1'b1 : rd_q;
        end
    end
    always_ff @(posedge clk_i)
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
endmodule

// File: rtl/uart_host_wbm.sv
// uart_host_wbm: Wishbone poller moving bytes between an 8251-style UART and tx/rx streams.
// UART_HOST_ERR_EN keeps the break/perr/ovf bits of the preceding status read with each rx byte.
module uart_host_wbm import uart_host_pkg::*; #(
    parameter int FIFO_AW = 2
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    output logic       wbm_adr_o,
    output logic [7:0] wbm_dat_o,
    input  logic [7:0] wbm_dat_i,
    output logic       wbm_cyc_o,
    output logic       wbm_stb_o,
    output logic       wbm_we_o,
    input  logic       wbm_ack_i,
    input  logic [7:0] tx_dat_i,
    input  logic       tx_vld_i,
    output logic       tx_rdy_o,
    output logic [7:0] rx_dat_o,
    output logic       rx_vld_o,
    input  logic       rx_rdy_i,
    output logic [2:0] rx_err_o
);
    state_t state_q, state_d;
    logic cyc_q, cyc_d, we_q, we_d, adr_q, adr_d;
    logic [7:0] dat_q, dat_d, stat_q, stat_d, tx_head;
    logic tx_full, tx_empty, tx_pop, rx_full, rx_empty, rx_push;
    logic [RX_W-1:0] rx_din, rx_dout;
    logic unused_stat;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o = we_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign tx_rdy_o = !wb_rst_i && !tx_full;
    assign rx_vld_o = !rx_empty;
    assign rx_dat_o = rx_dout[7:0];
`ifdef UART_HOST_ERR_EN
    assign rx_din = {stat_q[BRK:OVF], wbm_dat_i};
    assign rx_err_o = rx_dout[RX_W-1:8];
    assign unused_stat = ^stat_q[6:3];
`else
    assign rx_din = wbm_dat_i;
    assign rx_err_o = 3'b000;
    assign unused_stat = ^stat_q[6:0];
`endif
    uart_host_fifo #(.W(8), .AW(FIFO_AW)) u_tx_fifo (
        .clk_i(wb_clk_i), .rst_i(wb_rst_i), .push_i(tx_vld_i && tx_rdy_o), .din_i(tx_dat_i),
        .pop_i(tx_pop), .dout_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
    );
    uart_host_fifo #(.W(RX_W), .AW(FIFO_AW)) u_rx_fifo (
        .clk_i(wb_clk_i), .rst_i(wb_rst_i), .push_i(rx_push), .din_i(rx_din),
        .pop_i(rx_rdy_i && rx_vld_o), .dout_o(rx_dout), .full_o(rx_full), .empty_o(rx_empty)
    );
    // Each busy state spends its first cycle with the bus idle, then holds one cycle until ack
    always_comb begin
        state_d = state_q;
        cyc_d = cyc_q;
        we_d = we_q;
        adr_d = adr_q;
        dat_d = dat_q;
        stat_d = stat_q;
        rx_push = 1'b0;
        tx_pop = 1'b0;
        if (state_q == IDLE) begin
            state_d = STAT;
        end else if (!cyc_q) begin
            cyc_d = 1'b1;
            we_d = state_q == WDAT;
            adr_d = (state_q == STAT) ? ADR_CSR : ADR_DATA;
            dat_d = (state_q == WDAT) ? tx_head : 8'h00;
        end else if (wbm_ack_i) begin
            cyc_d = 1'b0;
            we_d = 1'b0;
            if (state_q == STAT) begin
                stat_d = wbm_dat_i;
                state_d = (wbm_dat_i[RXRDY] && !rx_full) ? RDAT :
                          (wbm_dat_i[TXRDY] && !tx_empty) ? WDAT : IDLE;
            end else if (state_q == RDAT) begin
                rx_push = 1'b1;
                state_d = (stat_q[TXRDY] && !tx_empty) ? WDAT : IDLE;
            end else begin
                tx_pop = 1'b1;
                state_d = IDLE;
            end
        end
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cyc_q <= 1'b0;
            we_q <= 1'b0;
            adr_q <= ADR_DATA;
            dat_q <= 8'h00;
            stat_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cyc_q <= cyc_d;
            we_q <= we_d;
            adr_q <= adr_d;
            dat_q <= dat_d;
            stat_q <= stat_d;
        end
    end
endmodule

// File: tb/tb_uart_host_wbm.sv
// tb_uart_host_wbm: UART slave model with wait states plus stream scoreboards for uart_host_wbm
module tb_uart_host_wbm;
    logic clk = 1'b0, rst = 1'b1;
    logic adr, cyc, stb, we, ack = 1'b0;
    logic [7:0] dat_o, rdata = 8'h00;
    logic [7:0] tx_dat = 8'h00, rx_dat;
    logic tx_vld = 1'b0, tx_rdy, rx_vld, rx_rdy = 1'b0;
    logic [2:0] rx_err;
    int checks = 0, errors = 0;
    logic [7:0] rx_src[$];
    logic [10:0] rx_exp[$];
    logic [7:0] tx_exp[$];
    int log_q[$];
    int ws = 0, wcnt = 0, stat_cnt = 0, rdat_cnt = 0, wdat_cnt = 0;
    bit txrdy = 0, mute = 0, rand_err = 0;
    logic [2:0] err_val = 3'b000, last_err = 3'b000, e;
    logic [7:0] st, b;
    logic p_cyc = 0, p_ack = 0, p_adr = 0, p_we = 0;
    logic [7:0] p_dat = 8'h00;
    logic [10:0] x;
    always #5 clk = ~clk;
    uart_host_wbm #(.FIFO_AW(2)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(rdata),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_ack_i(ack),
        .tx_dat_i(tx_dat), .tx_vld_i(tx_vld), .tx_rdy_o(tx_rdy),
        .rx_dat_o(rx_dat), .rx_vld_o(rx_vld), .rx_rdy_i(rx_rdy), .rx_err_o(rx_err)
    );
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    function automatic int lg(input int i);
        return (i >= 0 && i < log_q.size()) ? log_q[i] : -1;
    endfunction
    // UART slave: status = {txrdy,000,rx data waiting,err}; RBR pops the byte source
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack <= 1'b0;
            wcnt = 0;
        end else begin
            ack <= 1'b0;
            if (cyc && stb && !ack) begin
                if (wcnt < ws) wcnt++;
                else begin
                    wcnt = 0;
                    ack <= 1'b1;
                    if (adr) begin
                        chk("stat_we", we, 0);
                        e = rand_err ? 3'($urandom) : err_val;
                        st = mute ? 8'h00 : {txrdy, 3'b000, rx_src.size() != 0, e};
                        if (!mute) last_err = e;
                        rdata <= st;
                        stat_cnt++;
                        log_q.push_back(0);
                    end else if (!we) begin
                        chk("rdat_avail", rx_src.size() != 0, 1);
                        b = (rx_src.size() != 0) ? rx_src.pop_front() : 8'hEE;
                        rdata <= b;
                        rx_exp.push_back({last_err, b});
                        rdat_cnt++;
                        log_q.push_back(1);
                    end else begin
                        chk("wdat_avail", tx_exp.size() != 0, 1);
                        if (tx_exp.size() != 0) chk("wdat", dat_o, tx_exp.pop_front());
                        wdat_cnt++;
                        log_q.push_back(2);
                    end
                end
            end
        end
    end
    always @(negedge clk) begin
        if (!rst && rx_vld && rx_rdy) begin
            chk("rx_avail", rx_exp.size() != 0, 1);
            if (rx_exp.size() != 0) begin
                x = rx_exp.pop_front();
                chk("rx_dat", rx_dat, x[7:0]);
`ifdef UART_HOST_ERR_EN
                chk("rx_err", rx_err, x[10:8]);
`else
                chk("rx_err", rx_err, 0);
`endif
            end
        end
    end
    always @(negedge clk) begin
        if (rst) p_cyc = 0;
        else begin
            if (cyc && p_cyc) chk("bus_hold", {adr, we, dat_o, stb}, {p_adr, p_we, p_dat, 1'b1});
            if (p_ack && p_cyc) chk("cyc_drop", cyc, 0);
            p_cyc = cyc;
        end
        p_ack = ack;
        p_adr = adr;
        p_we = we;
        p_dat = dat_o;
    end
    task automatic send_tx(input logic [7:0] d);
        int n = 0;
        @(posedge clk); #1;
        tx_dat = d;
        tx_vld = 1'b1;
        @(negedge clk);
        while (!tx_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("tx_accept", tx_rdy, 1);
        if (tx_rdy) tx_exp.push_back(d);
        @(posedge clk); #1;
        tx_vld = 1'b0;
    endtask
    task automatic wait_done(input string nm, input int lim);
        int n = 0;
        while (!(tx_exp.size() == 0 && rx_exp.size() == 0 && rx_src.size() == 0 && !rx_vld) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done"}, tx_exp.size() + rx_exp.size() + rx_src.size(), 0);
    endtask
    task automatic set_rdy(input logic v);
        @(posedge clk); #1;
        rx_rdy = v;
    endtask
    initial begin
        int w0, r0, s0, n, iw, ir;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cyc", cyc, 0);
        chk("rst_stb", stb, 0);
        chk("rst_we", we, 0);
        chk("rst_adr", adr, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_rx_vld", rx_vld, 0);
        chk("rst_rx_err", rx_err, 0);
        chk("rst_tx_rdy", tx_rdy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rel_tx_rdy", tx_rdy, 1);
        // single tx byte
        txrdy = 1;
        rx_rdy = 1'b1;
        w0 = wdat_cnt;
        send_tx(8'h55);
        wait_done("t25", 200);
        iw = -1;
        foreach (log_q[k]) if (log_q[k] == 2) iw = k;
        chk("t25_wdat_seen", iw >= 0, 1);
        chk("t25_stat_before_wdat", lg(iw - 1), 0);
        repeat (20) @(negedge clk);
        chk("t25_one_write", wdat_cnt - w0, 1);
        // single rx byte and latency
        txrdy = 0;
        r0 = rdat_cnt;
        rx_src.push_back(8'hA3);
        n = 0;
        while (rdat_cnt == r0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!rx_vld && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("t26_latency_ok", n <= 2, 1);
        wait_done("t26", 100);
        // rx before tx within one round
        mute = 1;
        repeat (10) @(negedge clk);
        rx_src.push_back(8'hC4);
        send_tx(8'h01);
        log_q.delete();
        mute = 0;
        txrdy = 1;
        wait_done("t27", 300);
        ir = -1;
        for (int k = log_q.size() - 1; k >= 0; k--) if (log_q[k] != 0) ir = k;
        chk("t27_rdat_first", lg(ir), 1);
        chk("t27_wdat_next", lg(ir + 1), 2);
        chk("t27_stat_before", lg(ir - 1), 0);
        // rx FIFO fills and back-pressures
        txrdy = 0;
        set_rdy(1'b0);
        r0 = rdat_cnt;
        for (int k = 0; k < 5; k++) rx_src.push_back(8'($urandom));
        repeat (80) @(negedge clk);
        chk("t28_four_reads", rdat_cnt - r0, 4);
        s0 = stat_cnt;
        repeat (20) @(negedge clk);
        chk("t28_polling", stat_cnt > s0, 1);
        chk("t28_still_four", rdat_cnt - r0, 4);
        chk("t28_rx_vld", rx_vld, 1);
        set_rdy(1'b1);
        set_rdy(1'b0);
        repeat (30) @(negedge clk);
        chk("t28_fifth", rdat_cnt - r0, 5);
        set_rdy(1'b1);
        wait_done("t28", 200);
        // error bits travel with the byte
        err_val = 3'b010;
        rx_src.push_back(8'h7E);
        wait_done("t30", 200);
        err_val = 3'b000;
        // wait states
        ws = 3;
        txrdy = 1;
        rx_src.push_back(8'h3C);
        send_tx(8'h96);
        send_tx(8'h5A);
        wait_done("t29", 400);
        // randomized traffic
        rand_err = 1;
        for (int i = 0; i < 150; i++) begin
            ws = $urandom_range(0, 2);
            txrdy = $urandom_range(0, 3) != 0;
            @(negedge clk);
            if (tx_rdy && $urandom_range(0, 1) == 1) send_tx(8'($urandom));
            if ($urandom_range(0, 2) == 0 && rx_src.size() < 6) rx_src.push_back(8'($urandom));
            set_rdy($urandom_range(0, 3) != 0);
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end
        rand_err = 0;
        txrdy = 1;
        set_rdy(1'b1);
        wait_done("rand", 3000);
        // reset during a stretched bus cycle
        ws = 20;
        txrdy = 0;
        set_rdy(1'b0);
        rx_src.push_back(8'h11);
        rx_src.push_back(8'h22);
        n = 0;
        while (!rx_vld && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("mid_rx_vld", rx_vld, 1);
        n = 0;
        while (!cyc && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("mid_cyc_seen", cyc, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_cyc", cyc, 0);
        chk("mid_rst_stb", stb, 0);
        chk("mid_rst_rx_vld", rx_vld, 0);
        rx_exp.delete();
        tx_exp.delete();
        rx_src.delete();
        ws = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rel_tx_rdy", tx_rdy, 1);
        set_rdy(1'b1);
        txrdy = 1;
        rx_src.push_back(8'h5C);
        send_tx(8'hC5);
        wait_done("post_rst", 200);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end
endmodule

// File: doc/uart_host_wbm.md
UART_HOST_WBM -- requirements
Module: uart_host_wbm

Interface
REQ-001 SHALL have parameter: FIFO_AW, 2, log2 depth of each byte FIFO (depth 4).
REQ-002 SHALL have port: wb_clk_i  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: wbm_adr_o out 1 (0=data, 1=status/control); wbm_dat_o out 8; wbm_dat_i in 8; wbm_cyc_o out 1; wbm_stb_o out 1; wbm_we_o out 1; wbm_ack_i in 1.
REQ-005 SHALL have ports: tx_dat_i in 8, tx_vld_i in 1, tx_rdy_o out 1 (byte stream to transmit).
REQ-006 SHALL have ports: rx_dat_o out 8, rx_vld_o out 1, rx_rdy_i in 1 (received byte stream); rx_err_o out 3 ({break, perr, ovf}).

Function
REQ-007 SHALL act as Wishbone initiator to the 8251-style UART: status byte bit7 tx_ready, bit3 rx_ready, bits2..0 break/perr/ovf; data address read = RBR, write = THR.
REQ-008 SHALL contain a tx FIFO and an rx FIFO, each 2**FIFO_AW entries; tx_rdy_o = tx FIFO not full; rx_vld_o = rx FIFO not empty; transfer on vld&rdy.
REQ-009 SHALL run FSM states IDLE, STAT, RDAT, WDAT; each non-IDLE state issues exactly one bus cycle.
REQ-010 IDLE SHALL unconditionally go to STAT next cycle (continuous polling).
REQ-011 STAT: read adr 1; on ack latch wbm_dat_i; then RDAT if bit3=1 and rx FIFO not full, else WDAT if bit7=1 and tx FIFO not empty, else IDLE.
REQ-012 RDAT: read adr 0; on ack push wbm_dat_i into rx FIFO; then WDAT if latched bit7=1 and tx FIFO not empty, else IDLE.
REQ-013 WDAT: write adr 0 with tx FIFO head; pop head on ack; then IDLE.
REQ-014 cyc/stb/we/adr/dat SHALL be registered, asserted together on state entry, held constant until ack sampled high, deasserted the cycle after ack.
REQ-015 Minimum bus cycle SHALL be 2 clocks with single-cycle-ack slave; arbitrary wait states SHALL be tolerated.
REQ-016 rx priority over tx in each poll round; at most one read and one write per round.
REQ-017 Simultaneous FIFO push and pop SHALL both succeed, including when full (pop frees slot) or empty (push makes vld next cycle).
REQ-018 FIFO pointers SHALL be FIFO_AW+1 bits, wrapping naturally; full = MSB differ, low bits equal.

Reset
REQ-019 On wb_rst_i: FSM IDLE, cyc/stb/we 0, adr 0, dat_o 00, FIFOs empty, latched status 00, rx_vld_o 0, rx_err_o 000, tx_rdy_o 0 while reset asserted, 1 first cycle after release.
REQ-020 Reset mid bus cycle SHALL drop cyc/stb immediately (asynchronous) and discard FIFO contents; no ack is awaited.

Configuration
REQ-021 Macro UART_HOST_ERR_EN SHALL, when defined, widen rx FIFO to 11 bits storing status bits2..0 from the preceding STAT read with each byte, presented on rx_err_o alongside rx_dat_o.
REQ-022 Without UART_HOST_ERR_EN rx FIFO SHALL be 8 bits and rx_err_o SHALL be constant 000.

Structure
REQ-023 Shared package SHALL hold FSM state encoding, UART address constants (DATA=0, CSR=1), status bit indices (TXRDY=7, RXRDY=3, BRK=2, PERR=1, OVF=0).
REQ-024 One sub-module uart_host_fifo (parameters width, address width) SHALL be instantiated twice.

Verification
REQ-025 Push 8'h55 on tx with slave status 8'h80 -> one STAT read then write adr 0 data 8'h55 with we=1; tx FIFO empty after ack.
REQ-026 Slave status 8'h08, RBR 8'hA3 -> STAT then RDAT read adr 0; rx_vld_o=1, rx_dat_o=8'hA3 two cycles after RDAT ack at the latest.
REQ-027 Status 8'h88, tx pending 8'h01 -> order STAT, RDAT, WDAT; both bytes transferred in one round.
REQ-028 rx_rdy_i=0, 5 bytes offered with FIFO_AW=2 -> 4 bytes queued, no RDAT issued while full, status polling continues; 5th read after one pop.
REQ-029 Slave inserts 3 wait states -> cyc/stb/adr/dat stable until ack; reset asserted mid-cycle -> cyc/stb 0 same cycle, rx_vld_o 0.
REQ-030 With UART_HOST_ERR_EN, status 8'h0A, RBR 8'h7E -> rx_err_o=3'b010 with rx_dat_o=8'h7E.
